sync_event_tracker: RTL

SYNC_EVENT_TRACKER -- requirements
Module: sync_event_tracker

---
 rtl/sync_event_tracker.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sync_event_tracker.sv
// sync_event_tracker: decodes marker instructions on the commit lanes, tracks
// phase state and a protocol-error flag, counts markers per code, and runs an
// arm/expire transaction window.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  ST_IDLE  | no window open; waiting for an arming marker or spec_done
//  ST_ARMED | window open; timer counting down toward expiry
//  ST_DONE  | window closed; tsx_done high until INIT_START or reset
module sync_event_tracker #(
    parameter int          NUM_LANES = 2,
    parameter int          WINDOW    = 4,
    parameter int          CNT_W     = 16,
    parameter logic [14:0] ARM_MASK  = 15'h0012
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_LANES-1:0]   commit_valid,
    input  logic [32*NUM_LANES-1:0] commit_inst,
    input  logic                   spec_done,
    output logic [NUM_LANES-1:0]   evt_valid,
    output logic [4*NUM_LANES-1:0] evt_code,
    output logic [6:0]             phase_active,
    output logic                   phase_err,
    output logic                   tsx_done,
    output logic                   sim_exit,
    output logic [15*CNT_W-1:0]    evt_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int         TMR_W    = 8;
    localparam logic [TMR_W-1:0] WIN_LOAD = TMR_W'(WINDOW - 1);

    localparam logic [3:0] CODE_INIT_START = 4'd8;
    localparam logic [3:0] CODE_SIM_EXIT   = 4'd14;

    // Code 15 is not a marker, so its arm bit is forced to zero.
    localparam logic [15:0] ARM_VEC = {1'b0, ARM_MASK};

    logic [NUM_LANES-1:0] mk_valid;
    logic [3:0]           mk_code [NUM_LANES];
    logic                 arm_hit;
    logic                 init_hit;
    logic                 exit_hit;

    logic [6:0]           phase_nxt;
    logic                 err_nxt;

    logic [CNT_W-1:0]     cnt_q   [15];
    logic [CNT_W-1:0]     cnt_nxt [15];

    logic [1:0]           state_q;
    logic [1:0]           state_nxt;
    logic [TMR_W-1:0]     tmr_q;
    logic [TMR_W-1:0]     tmr_nxt;

    // Decode each lane's committed instruction into a marker code and summarize hits.
    always_comb begin
        arm_hit  = 1'b0;
        init_hit = 1'b0;
        exit_hit = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            mk_code[i]  = commit_inst[32*i+20 +: 4];
            mk_valid[i] = commit_valid[i]
                          && (commit_inst[32*i+24 +: 8] == 8'h00)
                          && (commit_inst[32*i +: 20] == 20'h02013)
                          && (mk_code[i] != 4'hf);
            if (mk_valid[i]) begin
                if (ARM_VEC[mk_code[i]])              arm_hit  = 1'b1;
                if (mk_code[i] == CODE_INIT_START)    init_hit = 1'b1;
                if (mk_code[i] == CODE_SIM_EXIT)      exit_hit = 1'b1;
            end
        end
    end

    // Apply phase START/END markers in ascending lane order, flagging protocol errors.
    always_comb begin
        phase_nxt = phase_active;
        err_nxt   = phase_err;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (mk_valid[i] && (mk_code[i] < CODE_SIM_EXIT)) begin
                if (!mk_code[i][0]) begin
                    if (phase_nxt[mk_code[i][3:1]]) err_nxt = 1'b1;
                    phase_nxt[mk_code[i][3:1]] = 1'b1;
                end else begin
                    if (!phase_nxt[mk_code[i][3:1]]) err_nxt = 1'b1;
                    phase_nxt[mk_code[i][3:1]] = 1'b0;
                end
            end
        end
    end

    // Saturating per-code counters; several lanes may hit the same code in one cycle.
    always_comb begin
        for (int k = 0; k < 15; k++) begin
            logic [3:0]       inc;
            logic [CNT_W+3:0] sum;
            inc = 4'd0;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (mk_valid[i] && (mk_code[i] == 4'(k))) inc = inc + 4'd1;
            end
            sum = {4'd0, cnt_q[k]} + {{CNT_W{1'b0}}, inc};
            if (sum[CNT_W+3:CNT_W] != 4'd0) cnt_nxt[k] = {CNT_W{1'b1}};
            else                            cnt_nxt[k] = sum[CNT_W-1:0];
        end
    end

    // Window FSM: spec_done forces DONE, INIT_START reopens, the timer expires the window.
    always_comb begin
        state_nxt = state_q;
        tmr_nxt   = tmr_q;
        case (state_q)
            ST_IDLE: begin
                if (spec_done) begin
                    state_nxt = ST_DONE;
                end else if (arm_hit) begin
                    tmr_nxt   = WIN_LOAD;
                    state_nxt = (WIN_LOAD == '0) ? ST_DONE : ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (spec_done) begin
                    state_nxt = ST_DONE;
                end else if (init_hit) begin
                    state_nxt = ST_IDLE;
                end else begin
                    // Terminal count: the timer reaches 0 on this edge, so DONE follows it.
                    tmr_nxt = tmr_q - 1'b1;
                    if (tmr_q == TMR_W'(1)) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (init_hit) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Register all tracker state; reset discards any markers in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            evt_valid    <= '0;
            evt_code     <= '0;
            phase_active <= '0;
            phase_err    <= 1'b0;
            sim_exit     <= 1'b0;
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            for (int k = 0; k < 15; k++) cnt_q[k] <= '0;
        end else begin
            evt_valid    <= mk_valid;
            for (int i = 0; i < NUM_LANES; i++)
                evt_code[4*i +: 4] <= mk_valid[i] ? mk_code[i] : 4'd0;
            phase_active <= phase_nxt;
            phase_err    <= err_nxt;
            sim_exit     <= sim_exit | exit_hit;
            state_q      <= state_nxt;
            tmr_q        <= tmr_nxt;
            for (int k = 0; k < 15; k++) cnt_q[k] <= cnt_nxt[k];
        end
    end

    assign tsx_done = (state_q == ST_DONE);

    for (genvar k = 0; k < 15; k++) begin : g_cnt_out
        assign evt_count[CNT_W*k +: CNT_W] = cnt_q[k];
    end

endmodule
